// File: rtl/hilo_mul_unit.sv
// Multi-cycle multiply / HI-LO unit executing MULT, MULTU, MUL, MADD, MSUB and the HI/LO moves.
// Iterative radix-2 shift-add core on operand magnitudes, sign applied in a single fixup cycle.
module hilo_mul_unit #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [5:0]        ALUControl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Result,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam logic [5:0] OP_MULT  = 6'd3;
  localparam logic [5:0] OP_MULTU = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd19;
  localparam logic [5:0] OP_MADD  = 6'd20;
  localparam logic [5:0] OP_MSUB  = 6'd21;
  localparam logic [5:0] OP_MFHI  = 6'd23;
  localparam logic [5:0] OP_MFLO  = 6'd24;
  localparam logic [5:0] OP_MTHI  = 6'd25;
  localparam logic [5:0] OP_MTLO  = 6'd26;

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_FIXUP, S_DONE} state_t;

  state_t              state_q;
  logic [5:0]          op_q;
  logic                sign_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PW-1:0]       mcand_q;
  logic [PW-1:0]       acc_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   result_q;
  logic [PW-1:0]       prod_d;
  logic [PW-1:0]       hilo_d;

  // The most negative operand maps to 2^(DATA_W-1), which still fits unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? -v : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
    return neg ? -p : p;
  endfunction

  function automatic logic is_mul_op(input logic [5:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB};
  endfunction

  always_comb begin
    prod_d = apply_sign(acc_q, sign_q);
    case (op_q)
      OP_MULT, OP_MULTU: hilo_d = prod_d;
      OP_MADD:           hilo_d = {hi_q, lo_q} + prod_d;
      OP_MSUB:           hilo_d = {hi_q, lo_q} - prod_d;
      default:           hilo_d = {hi_q, lo_q};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_MULT: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          hi_q     <= hilo_d[PW-1:DATA_W];
          lo_q     <= hilo_d[DATA_W-1:0];
          result_q <= (op_q == OP_MUL) ? prod_d[DATA_W-1:0] : hilo_d[DATA_W-1:0];
          state_q  <= S_DONE;
        end
        default: begin
          // IDLE and DONE both accept; accepting in DONE gives back-to-back issue.
          if (Start) begin
            op_q <= ALUControl;
            if (is_mul_op(ALUControl)) begin
              state_q <= S_MULT;
              acc_q   <= '0;
              cnt_q   <= '0;
              if (ALUControl == OP_MULTU) begin
                mcand_q  <= {{DATA_W{1'b0}}, A};
                mplier_q <= B;
                sign_q   <= 1'b0;
              end else begin
                mcand_q  <= {{DATA_W{1'b0}}, magnitude(A)};
                mplier_q <= magnitude(B);
                sign_q   <= A[DATA_W-1] ^ B[DATA_W-1];
              end
            end else begin
              state_q <= S_DONE;
              case (ALUControl)
                OP_MFHI: result_q <= hi_q;
                OP_MFLO: result_q <= lo_q;
                OP_MTHI: begin
                  hi_q     <= A;
                  result_q <= '0;
                end
                OP_MTLO: begin
                  lo_q     <= A;
                  result_q <= '0;
                end
                default: result_q <= '0;
              endcase
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Busy   = (state_q == S_MULT) || (state_q == S_FIXUP);
  assign Done   = (state_q == S_DONE);
  assign Result = result_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Bench for hilo_mul_unit: directed scenarios plus randomized ops against a 64-bit arithmetic model.
module tb_hilo_mul_unit;

  localparam int W   = 32;
  localparam int MUL_LAT = W + 2;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [5:0]   ALUControl = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done;
  logic [W-1:0] Result, HI, LO;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  hilo_mul_unit #(.DATA_W(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUControl(ALUControl), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Reference model: full-width products with native 64-bit arithmetic.
  task automatic model_exec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] res, output int lat);
    longint sa, sb;
    logic [63:0] p, hl, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 6'd4) p = ua * ub;
    else            p = sa * sb;
    hl  = {m_hi, m_lo};
    res = '0;
    lat = 1;
    case (op)
      6'd3, 6'd4: begin hl = p;      res = hl[31:0]; lat = MUL_LAT; end
      6'd19:      begin              res = p[31:0];  lat = MUL_LAT; end
      6'd20:      begin hl = hl + p; res = hl[31:0]; lat = MUL_LAT; end
      6'd21:      begin hl = hl - p; res = hl[31:0]; lat = MUL_LAT; end
      6'd23:      res = m_hi;
      6'd24:      res = m_lo;
      6'd25:      hl[63:32] = a;
      6'd26:      hl[31:0]  = a;
      default:    ;
    endcase
    m_hi = hl[63:32];
    m_lo = hl[31:0];
  endtask

  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit to);
    @(negedge Clk);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 1;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    to = (Done !== 1'b1);
  endtask

  task automatic test_reset();
    int lat, dones;
    bit to;
    logic [31:0] r;
    #2;
    n_checks++; if ({Busy, Done, Result, HI, LO} !== '0) begin n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b res=%h hi=%h lo=%h required all zero", Busy, Done, Result, HI, LO); end
    @(negedge Clk); Rst = 1'b1;
    model_exec(6'd26, 32'd5, 32'd0, r, lat);
    do_op(6'd26, 32'd5, 32'd0, lat, to);
    n_checks++; if (LO !== 32'd5 || to) begin n_fail++; $display("FAIL mtlo_pre: got lo=%h required 5", LO); end
    // Reset in the middle of a multiply.
    @(negedge Clk); Start = 1'b1; ALUControl = 6'd3; A = -32'sd3; B = 32'd7;
    @(posedge Clk); #1; Start = 1'b0;
    repeat (9) @(posedge Clk);
    #2; Rst = 1'b0; #1;
    n_checks++; if ({Busy, Done, Result, HI, LO} !== '0) begin n_fail++;
      $display("FAIL reset_mid_mult: got busy=%b done=%b res=%h hi=%h lo=%h required all zero", Busy, Done, Result, HI, LO); end
    m_hi = '0; m_lo = '0;
    @(negedge Clk); Rst = 1'b1;
    dones = 0;
    repeat (40) begin @(posedge Clk); #1; if (Done === 1'b1 || Busy === 1'b1) dones++; end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL reset_no_late_done: got %0d busy/done cycles required 0", dones); end
    n_checks++; if ({HI, LO} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h%h required 0", HI, LO); end
  endtask

  task automatic test_mult_signed();
    int lat, mlat;
    bit to;
    logic [31:0] r;
    model_exec(6'd3, -32'sd3, 32'd7, r, mlat);
    do_op(6'd3, -32'sd3, 32'd7, lat, to);
    n_checks++; if (to || lat !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d timeout=%0d required 34", lat, to); end
    n_checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin n_fail++;
      $display("FAIL mult_neg: got hi=%h lo=%h required FFFFFFFF FFFFFFEB", HI, LO); end
    n_checks++; if (Result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_result: got %h required FFFFFFEB", Result); end
    model_exec(6'd24, 32'd0, 32'd0, r, mlat);
    do_op(6'd24, 32'd0, 32'd0, lat, to);
    n_checks++; if (to || lat !== 1 || Result !== 32'hFFFFFFEB) begin n_fail++;
      $display("FAIL mflo: got lat=%0d res=%h required 1 FFFFFFEB", lat, Result); end
  endtask

  task automatic test_mult_corner();
    int lat, mlat;
    bit to;
    logic [31:0] r;
    model_exec(6'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, r, mlat);
    do_op(6'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, to);
    n_checks++; if (to || HI !== 32'hFFFFFFFE || LO !== 32'h1) begin n_fail++;
      $display("FAIL multu_max: got hi=%h lo=%h required FFFFFFFE 00000001", HI, LO); end
    model_exec(6'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, r, mlat);
    do_op(6'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, to);
    n_checks++; if (to || HI !== 32'h0 || LO !== 32'h1) begin n_fail++;
      $display("FAIL mult_m1: got hi=%h lo=%h required 0 1", HI, LO); end
    model_exec(6'd3, 32'h80000000, 32'h80000000, r, mlat);
    do_op(6'd3, 32'h80000000, 32'h80000000, lat, to);
    n_checks++; if (to || HI !== 32'h40000000 || LO !== 32'h0) begin n_fail++;
      $display("FAIL mult_minneg: got hi=%h lo=%h required 40000000 0", HI, LO); end
  endtask

  task automatic test_madd_msub();
    int lat, mlat;
    bit to;
    logic [31:0] r;
    model_exec(6'd25, 32'd0, 32'd0, r, mlat); do_op(6'd25, 32'd0, 32'd0, lat, to);
    n_checks++; if (to || HI !== 32'd0 || Result !== 32'd0) begin n_fail++; $display("FAIL mthi: got hi=%h res=%h required 0 0", HI, Result); end
    model_exec(6'd26, 32'd5, 32'd0, r, mlat); do_op(6'd26, 32'd5, 32'd0, lat, to);
    n_checks++; if (to || LO !== 32'd5) begin n_fail++; $display("FAIL mtlo: got lo=%h required 5", LO); end
    model_exec(6'd20, 32'd2, 32'd3, r, mlat); do_op(6'd20, 32'd2, 32'd3, lat, to);
    n_checks++; if (to || LO !== 32'h0B || HI !== 32'd0) begin n_fail++; $display("FAIL madd: got hi=%h lo=%h required 0 0B", HI, LO); end
    model_exec(6'd21, 32'hFFFFFFFF, 32'h0B, r, mlat); do_op(6'd21, 32'hFFFFFFFF, 32'h0B, lat, to);
    n_checks++; if (to || LO !== 32'h16 || HI !== 32'd0) begin n_fail++; $display("FAIL msub: got hi=%h lo=%h required 0 16", HI, LO); end
    model_exec(6'd19, 32'd4, 32'd5, r, mlat); do_op(6'd19, 32'd4, 32'd5, lat, to);
    n_checks++; if (to || Result !== 32'h14 || HI !== 32'd0 || LO !== 32'h16) begin n_fail++;
      $display("FAIL mul: got res=%h hi=%h lo=%h required 14 0 16", Result, HI, LO); end
  endtask

  task automatic test_busy_ignore();
    int mlat, dones, done_at;
    logic [31:0] r, a, b;
    a = $urandom; b = $urandom;
    model_exec(6'd3, a, b, r, mlat);
    @(negedge Clk); Start = 1'b1; ALUControl = 6'd3; A = a; B = b;
    @(posedge Clk); #1;
    dones = 0; done_at = 0;
    for (int c = 1; c <= 45; c++) begin
      if (Done === 1'b1) begin dones++; done_at = c; end
      Start = (c == 3 || c == 10 || c == 20 || c == 30);
      ALUControl = 6'd25; A = 32'hDEADBEEF; B = 32'h12345678;
      @(posedge Clk); #1;
    end
    Start = 1'b0;
    n_checks++; if (dones !== 1 || done_at !== MUL_LAT) begin n_fail++;
      $display("FAIL busy_one_done: got %0d dones at %0d required 1 at %0d", dones, done_at, MUL_LAT); end
    n_checks++; if (HI !== m_hi || LO !== m_lo) begin n_fail++;
      $display("FAIL busy_hilo: got %h %h required %h %h", HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_back_to_back();
    int lat, mlat;
    bit to;
    logic [31:0] r;
    model_exec(6'd3, 32'h7FFFFFFF, 32'hFFFFFFFE, r, mlat);
    do_op(6'd3, 32'h7FFFFFFF, 32'hFFFFFFFE, lat, to);
    n_checks++; if (to || lat !== MUL_LAT || Result !== r) begin n_fail++;
      $display("FAIL b2b_first: got lat=%0d res=%h required %0d %h", lat, Result, MUL_LAT, r); end
    model_exec(6'd23, 32'd0, 32'd0, r, mlat);
    do_op(6'd23, 32'd0, 32'd0, lat, to);
    n_checks++; if (to || lat !== 1 || Result !== r) begin n_fail++;
      $display("FAIL b2b_mfhi: got lat=%0d res=%h required 1 %h", lat, Result, r); end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [5:0] ops [11] = '{6'd3, 6'd4, 6'd19, 6'd20, 6'd21, 6'd23, 6'd24, 6'd25, 6'd26, 6'd0, 6'd7};
    int lat, mlat;
    bit to;
    logic [31:0] r, a, b;
    logic [5:0] op;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 10)];
      a = rnd_operand(); b = rnd_operand();
      model_exec(op, a, b, r, mlat);
      do_op(op, a, b, lat, to);
      n_checks++; if (to || lat !== mlat || Result !== r || HI !== m_hi || LO !== m_lo) begin n_fail++;
        $display("FAIL random_op%0d: op=%0d a=%h b=%h got lat=%0d res=%h hi=%h lo=%h required %0d %h %h %h",
                 i, op, a, b, lat, Result, HI, LO, mlat, r, m_hi, m_lo); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult_signed();
    test_mult_corner();
    test_madd_msub();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
